riscv_if_fetch_ctrl: RTL and testbench

Instruction-fetch request sequencer that sits between the BIU and the parcel queue. It generates bus-aligned fetch addresses, issues requests while the queue has room, and tracks outstanding responses. It converts each response into a parcel write with the correct parcel-valid mask. On a flush it redirects to a new PC and silently drops responses belonging to pre-flush requests.

---
 rtl/riscv_if_pkg.sv | 19 +
 rtl/riscv_if_tag_fifo.sv | 58 +++++
 rtl/riscv_if_fetch_ctrl.sv | 156 +++++++++++++++
 tb/tb_riscv_if_fetch_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_if_pkg.sv
// riscv_if_pkg: types and constants shared by the instruction-fetch blocks.
//   fetch_tag_t   : parcel offset of a request inside its bus beat
//   fetch_state_t : fetch sequencer state
//   BUS_BYTES     : bytes per bus beat for the default two-parcel bus
package riscv_if_pkg;

  localparam int unsigned DEF_BUS_PARCELS = 2;
  localparam int unsigned BUS_BYTES       = DEF_BUS_PARCELS * 2;
  localparam int unsigned TAG_W           = $clog2(BUS_BYTES) - 1;

  typedef logic [TAG_W-1:0] fetch_tag_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/riscv_if_tag_fifo.sv
// riscv_if_tag_fifo: in-order FIFO that holds the parcel offset of every
// accepted fetch request until its response returns.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i, din_i : write an entry (ignored when full)
//   pop_i, dout_o : drop the head entry (ignored when empty); dout_o is the head
//   empty_o, full_o
// There is no bypass: an entry pushed this cycle cannot be popped this cycle.
module riscv_if_tag_fifo
  import riscv_if_pkg::*;
#(
  parameter int unsigned W     = $bits(fetch_tag_t),
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok, pop_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count == '0);
  assign full_o  = (count == CW'(DEPTH));
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/riscv_if_fetch_ctrl.sv
// riscv_if_fetch_ctrl: instruction-fetch request sequencer between the BIU
// and the parcel queue.
//   flush_i/flush_pc_i     : redirect fetch (highest priority)
//   q_almost_full_i        : parcel queue back-pressure
//   biu_stb_o/biu_adr_o    : registered fetch request, beat aligned
//   biu_stb_ack_i          : request accepted
//   biu_d_ack_i, biu_q_i, biu_err_i, biu_page_fault_i : in-order response
//   parcel_o/parcel_valid_o/parcel_error_o/parcel_page_fault_o : queue write,
//                            combinational from the response
//   busy_o                 : requests outstanding
//   state_o                : sequencer state, for observation
//
// Handshake: a request transfers on a cycle where biu_stb_o && biu_stb_ack_i.
// Once raised, biu_stb_o and biu_adr_o stay stable until that transfer; only a
// flush withdraws an unaccepted request. Responses (biu_d_ack_i) carry no ready
// and arrive in request order.
module riscv_if_fetch_ctrl
  import riscv_if_pkg::*;
#(
  parameter int unsigned          XLEN            = 32,
  parameter logic [XLEN-1:0]      PC_INIT         = 'h200,
  parameter int unsigned          BUS_PARCELS     = BUS_BYTES / 2,
  parameter int unsigned          MAX_OUTSTANDING = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic [XLEN-1:0]           flush_pc_i,
  input  logic                      q_almost_full_i,
  output logic                      biu_stb_o,
  output logic [XLEN-1:0]           biu_adr_o,
  input  logic                      biu_stb_ack_i,
  input  logic                      biu_d_ack_i,
  input  logic [BUS_PARCELS*16-1:0] biu_q_i,
  input  logic                      biu_err_i,
  input  logic                      biu_page_fault_i,
  output logic [BUS_PARCELS*16-1:0] parcel_o,
  output logic [BUS_PARCELS-1:0]    parcel_valid_o,
  output logic                      parcel_error_o,
  output logic                      parcel_page_fault_o,
  output logic                      busy_o,
  output fetch_state_t              state_o
);

  localparam int unsigned BEAT_BYTES = BUS_PARCELS * 2;
  localparam int unsigned OFF_W      = $clog2(BEAT_BYTES) - 1;
  localparam int unsigned CNT_W      = $clog2(MAX_OUTSTANDING) + 1;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(BEAT_BYTES - 1);
  endfunction

  fetch_state_t     state_q, state_d;
  logic [XLEN-1:0]  adr_q;
  logic             stb_q;
  logic [CNT_W-1:0] out_q, out_nxt;
  logic [CNT_W-1:0] disc_q, disc_nxt;
  logic [OFF_W-1:0] off_q, tag;
  logic             acc, resp, stall_cond, issue, deliver;
  logic             tag_empty, tag_full;

  // Responses are only counted when a tag exists, so a stray d_ack cannot
  // underflow the counters.
  assign acc        = stb_q && biu_stb_ack_i;
  assign resp       = biu_d_ack_i && !tag_empty;
  assign out_nxt    = out_q + CNT_W'(acc) - CNT_W'(resp);
  assign stall_cond = q_almost_full_i || (out_nxt == CNT_W'(MAX_OUTSTANDING));

  // A flush captures everything still in flight after this cycle, which
  // includes a request the BIU accepts in the flush cycle itself.
  always_comb begin
    disc_nxt = disc_q;
    if (flush_i)                    disc_nxt = out_nxt;
    else if (resp && disc_q != '0)  disc_nxt = disc_q - 1'b1;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = (out_nxt != '0) ? ST_DRAIN : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   if (stall_cond)       state_d = ST_STALL;
        ST_STALL: if (!stall_cond)      state_d = ST_RUN;
        ST_DRAIN: if (disc_nxt == '0)   state_d = ST_RUN;
        default:                        state_d = ST_RUN;
      endcase
    end
  end

  // Output logic: a new request may be launched only when heading into RUN
  // with room for it.
  always_comb begin
    state_o = state_q;
    issue   = !flush_i && (state_d == ST_RUN) && !stall_cond;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      adr_q  <= align_pc(PC_INIT);
      off_q  <= PC_INIT[OFF_W:1];
      stb_q  <= 1'b0;
      out_q  <= '0;
      disc_q <= '0;
    end else begin
      out_q  <= out_nxt;
      disc_q <= disc_nxt;
      if (flush_i) begin
        adr_q <= align_pc(flush_pc_i);
        off_q <= flush_pc_i[OFF_W:1];
        stb_q <= 1'b0;
      end else begin
        if (acc) begin
          adr_q <= adr_q + XLEN'(BEAT_BYTES);
          off_q <= '0;
        end
        // An unaccepted request is held regardless of back-pressure.
        if (!stb_q || acc) stb_q <= issue;
      end
    end
  end

  riscv_if_tag_fifo #(
    .W     (OFF_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (acc),
    .din_i   (off_q),
    .pop_i   (resp),
    .dout_o  (tag),
    .empty_o (tag_empty),
    .full_o  (tag_full)
  );

  // Outstanding is bounded by the issue rule, so the tag FIFO never overflows.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(acc && tag_full && !resp));

  assign deliver             = resp && (disc_q == '0);
  assign biu_stb_o           = stb_q;
  assign biu_adr_o           = adr_q;
  assign parcel_o            = biu_q_i;
  assign parcel_valid_o      = deliver ? ({BUS_PARCELS{1'b1}} << tag) : '0;
  assign parcel_error_o      = deliver && biu_err_i;
  assign parcel_page_fault_o = deliver && biu_page_fault_i;
  assign busy_o              = (out_q != '0);

endmodule

// File: tb/tb_riscv_if_fetch_ctrl.sv
// tb_riscv_if_fetch_ctrl: directed bench for riscv_if_fetch_ctrl with an
// in-bench request/response model and a per-cycle compare process.
module tb_riscv_if_fetch_ctrl;
  import riscv_if_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        q_af = 1'b0;
  logic        stb;
  logic [31:0] adr;
  logic        stb_ack = 1'b0;
  logic        d_ack = 1'b0;
  logic [31:0] biu_q = '0;
  logic        biu_err = 1'b0;
  logic        biu_pf = 1'b0;
  logic [31:0] parcel;
  logic [1:0]  pvalid;
  logic        perr, ppf, busy;
  fetch_state_t state;

  riscv_if_fetch_ctrl #(
    .XLEN(32), .PC_INIT(32'h200), .BUS_PARCELS(2), .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .flush_pc_i(flush_pc),
    .q_almost_full_i(q_af), .biu_stb_o(stb), .biu_adr_o(adr),
    .biu_stb_ack_i(stb_ack), .biu_d_ack_i(d_ack), .biu_q_i(biu_q),
    .biu_err_i(biu_err), .biu_page_fault_i(biu_pf), .parcel_o(parcel),
    .parcel_valid_o(pvalid), .parcel_error_o(perr),
    .parcel_page_fault_o(ppf), .busy_o(busy), .state_o(state)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] mk_mask(input logic off);
    logic [1:0] ones;
    ones = 2'b11;
    return ones << off;
  endfunction

  // ---------------- BIU driver ----------------
  logic auto_a = 1'b0, auto_d = 1'b0, d_once = 1'b0, err_drv = 1'b0;
  int   pend = 0;

  always @(negedge clk) begin
    #1;
    stb_ack = auto_a;
    d_ack   = rst_n && (auto_d || d_once) && (pend > 0);
    biu_q   = $urandom;
    biu_err = err_drv && d_ack;
    biu_pf  = d_ack && ($urandom_range(0, 3) == 0);
  end

  // ---------------- model + scoreboard ----------------
  logic [1:0]  exp_q[$];     // expected valid mask per in-flight request
  logic [31:0] m_adr = 32'h200;
  logic        m_off = 1'b0;
  logic        hold_v = 1'b0, no_new = 1'b0;
  logic [31:0] hold_adr = '0;
  logic [31:0] acc_log[$];
  time         acc_t[$];
  logic [1:0]  resp_log[$];
  logic        err_log[$];

  always @(negedge clk) begin
    logic [1:0] e;
    #4;
    if (!rst_n) begin
      exp_q.delete();
      m_adr = 32'h200; m_off = 1'b0;
      hold_v = 1'b0; no_new = 1'b0; pend = 0;
    end else begin
      if (hold_v) begin
        chk("stb_hold", 32'(stb), 32'd1);
        chk("adr_hold", adr, hold_adr);
      end else if (no_new) begin
        chk("stall_no_new_stb", 32'(stb), 32'd0);
      end
      chk("busy", 32'(busy), 32'(exp_q.size() != 0));
      if (stb) chk("outstanding_limit", 32'(exp_q.size() < 2), 32'd1);
      if (d_ack) begin
        if (exp_q.size() == 0) begin
          chk("spurious_response", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("valid_mask", 32'(pvalid), 32'(e));
          chk("error_out", 32'(perr), 32'((e != 2'b00) && biu_err));
          chk("pf_out", 32'(ppf), 32'((e != 2'b00) && biu_pf));
          if (e != 2'b00) chk("parcel_data", parcel, biu_q);
          resp_log.push_back(pvalid);
          err_log.push_back(perr);
        end
      end else begin
        chk("valid_idle", 32'(pvalid), 32'd0);
      end
      if (stb && stb_ack) begin
        chk("req_adr", adr, m_adr);
        acc_log.push_back(adr);
        acc_t.push_back($time);
        exp_q.push_back(mk_mask(m_off));
        m_adr = m_adr + 32'd4;
        m_off = 1'b0;
      end
      if (flush) begin
        foreach (exp_q[i]) exp_q[i] = 2'b00;
        m_adr = flush_pc & ~32'd3;
        m_off = flush_pc[1];
      end
      hold_v   = stb && !stb_ack && !flush;
      hold_adr = adr;
      no_new   = q_af;
      pend     = exp_q.size();
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    acc_log.delete(); acc_t.delete(); resp_log.delete(); err_log.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    cyc(2);
    #4;
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_adr", adr, 32'h200);
    chk("rst_busy", 32'(busy), 32'd0);

    // 1: back-to-back fetch from PC_INIT
    @(negedge clk);
    rst_n = 1'b1; auto_a = 1'b1; auto_d = 1'b1;
    clear_logs();
    #4;
    chk("rel_stb_first_cycle", 32'(stb), 32'd0);
    chk("rel_state", 32'(state), 32'(ST_RUN));
    chk("rel_valid", 32'(pvalid), 32'd0);
    chk("rel_err", 32'(perr), 32'd0);
    chk("rel_pf", 32'(ppf), 32'd0);
    cyc(7);
    chk("s1_adr0", acc_log[0], 32'h200);
    chk("s1_adr1", acc_log[1], 32'h204);
    chk("s1_adr2", acc_log[2], 32'h208);
    chk("s1_b2b", 32'(acc_t[1] - acc_t[0]), 32'd10);
    chk("s1_b2b2", 32'(acc_t[2] - acc_t[1]), 32'd10);
    chk("s1_mask0", 32'(resp_log[0]), 32'd3);
    chk("s1_mask1", 32'(resp_log[1]), 32'd3);

    // 2: flush to 'h102 with nothing outstanding; the held stb is dropped
    auto_a = 1'b0;
    for (int i = 0; i < 40 && pend != 0; i++) cyc(1);
    chk("s2_drain_wait", 32'(pend), 32'd0);
    flush = 1'b1; flush_pc = 32'h102;
    clear_logs();
    cyc(1);
    flush = 1'b0; auto_a = 1'b1;
    #4;
    chk("s2_stb_dropped", 32'(stb), 32'd0);
    chk("s2_state", 32'(state), 32'(ST_RUN));
    cyc(6);
    chk("s2_adr0", acc_log[0], 32'h100);
    chk("s2_adr1", acc_log[1], 32'h104);
    chk("s2_mask0", 32'(resp_log[0]), 32'd2);
    chk("s2_mask1", 32'(resp_log[1]), 32'd3);

    // 3: two in flight, flush to 'h300, both responses discarded
    auto_d = 1'b0;
    for (int i = 0; i < 40 && pend != 2; i++) cyc(1);
    chk("s3_fill_wait", 32'(pend), 32'd2);
    auto_a = 1'b0; flush = 1'b1; flush_pc = 32'h300;
    clear_logs();
    cyc(1);
    flush = 1'b0;
    #4;
    chk("s3_state_drain", 32'(state), 32'(ST_DRAIN));
    chk("s3_busy", 32'(busy), 32'd1);
    chk("s3_no_stb", 32'(stb), 32'd0);
    cyc(1);
    auto_d = 1'b1; auto_a = 1'b1;
    cyc(8);
    chk("s3_drop0", 32'(resp_log[0]), 32'd0);
    chk("s3_drop1", 32'(resp_log[1]), 32'd0);
    chk("s3_adr0", acc_log[0], 32'h300);
    chk("s3_mask_after", 32'(resp_log[2]), 32'd3);

    // 4: almost-full while a request is pending
    auto_a = 1'b0;
    for (int i = 0; i < 40 && !(stb && pend == 0); i++) cyc(1);
    chk("s4_pending_wait", 32'(stb && pend == 0), 32'd1);
    q_af = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      #4;
      chk("s4_stb_held", 32'(stb), 32'd1);
      chk("s4_adr_held", adr, m_adr);
    end
    cyc(1);
    auto_a = 1'b1;
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      #4;
      chk("s4_af_no_stb", 32'(stb), 32'd0);
    end
    chk("s4_state_stall", 32'(state), 32'(ST_STALL));
    cyc(1);
    q_af = 1'b0; auto_a = 1'b0;
    cyc(1);
    #4;
    chk("s4_stb_resume", 32'(stb), 32'd1);

    // 5: responses withheld, outstanding limit of two
    cyc(1);
    auto_d = 1'b0; auto_a = 1'b1;
    clear_logs();
    cyc(6);
    #4;
    chk("s5_two_acks", 32'(acc_log.size()), 32'd2);
    chk("s5_stb_low", 32'(stb), 32'd0);
    chk("s5_busy", 32'(busy), 32'd1);
    chk("s5_state", 32'(state), 32'(ST_STALL));
    cyc(1);
    d_once = 1'b1;
    cyc(1);
    d_once = 1'b0;
    cyc(4);
    #4;
    chk("s5_third_ack", 32'(acc_log.size()), 32'd3);
    chk("s5_one_resp", 32'(resp_log.size()), 32'd1);
    chk("s5_stb_low2", 32'(stb), 32'd0);

    // 6: bus error on responses, then reset mid-burst
    cyc(1);
    auto_d = 1'b1; err_drv = 1'b1;
    clear_logs();
    cyc(3);
    err_drv = 1'b0;
    chk("s6_err", 32'(err_log[0]), 32'd1);
    chk("s6_err_mask", 32'(resp_log[0]), 32'd3);
    cyc(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_stb", 32'(stb), 32'd0);
    chk("arst_adr", adr, 32'h200);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(pvalid), 32'd0);
    chk("arst_err", 32'(perr), 32'd0);
    chk("arst_pf", 32'(ppf), 32'd0);
    chk("arst_state", 32'(state), 32'(ST_RUN));
    cyc(3);
    rst_n = 1'b1;
    clear_logs();
    cyc(5);
    chk("s6_restart_adr", acc_log[0], 32'h200);
    chk("s6_restart_mask", 32'(resp_log[0]), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
